// File: rtl/dm_access_ctrl.sv
// Load/store controller between the multicycle CPU datapath and the data memory.
// Adds sign/zero extension on loads, read-modify-write for sb/sh, and alignment/range rejection.
module dm_access_ctrl #(
  parameter int ADDR_W   = 14,
  parameter int DM_BYTES = 12288
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RESP = 2'b11
  } state_t;

  localparam logic [1:0]        SZ_B      = 2'b00;
  localparam logic [1:0]        SZ_H      = 2'b01;
  localparam logic [1:0]        SZ_W      = 2'b10;
  localparam logic [1:0]        SZ_BAD    = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(DM_BYTES - 4);

  state_t            r_state;
  state_t            w_next;
  logic              w_bad;
  logic              r_wr;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic [31:0]       r_rdata;
  logic              r_done;
  logic              r_err;
  logic              r_busy;
  logic              r_dm_we;
  logic [ADDR_W-1:0] r_dm_addr;

  // Memory has no byte enables, so sub-word stores splice new bytes into the word just read.
  function automatic logic [31:0] merge_store(input logic [1:0] sz, input logic [31:0] old_w,
                                              input logic [31:0] new_w);
    logic [31:0] m;
    m = old_w;
    case (sz)
      SZ_B:    m[7:0]  = new_w[7:0];
      SZ_H:    m[15:0] = new_w[15:0];
      default: m       = new_w;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic sx,
                                           input logic [31:0] w);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = {{24{sx & w[7]}}, w[7:0]};
      SZ_H:    r = {{16{sx & w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign w_bad = (size == SZ_BAD) ||
                 ((size == SZ_H) && addr[0]) ||
                 ((size == SZ_W) && (addr[1:0] != 2'b00)) ||
                 (addr > LAST_BASE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; req outside IDLE is simply not looked at.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!req) begin
          w_next = S_IDLE;
        end else if (w_bad) begin
          w_next = S_RESP;
        end else if (wr && (size == SZ_W)) begin
          w_next = S_WR;
        end else begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        if (r_wr) begin
          w_next = S_WR;
        end else begin
          w_next = S_RESP;
        end
      end
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latches, read buffer and registered handshake/memory strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr      <= 1'b0;
      r_size    <= 2'b00;
      r_sext    <= 1'b0;
      r_wdata   <= 32'h0000_0000;
      r_buf     <= 32'h0000_0000;
      r_rdata   <= 32'h0000_0000;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_dm_we   <= 1'b0;
      r_dm_addr <= {ADDR_W{1'b0}};
    end else begin
      if ((r_state == S_IDLE) && req) begin
        r_wr    <= wr;
        r_size  <= size;
        r_sext  <= sext;
        r_wdata <= wdata;
      end else begin
        r_wr    <= r_wr;
        r_size  <= r_size;
        r_sext  <= r_sext;
        r_wdata <= r_wdata;
      end
      // Rejected accesses never move dm_addr, so memory sees nothing of them.
      if ((r_state == S_IDLE) && ((w_next == S_RD) || (w_next == S_WR))) begin
        r_dm_addr <= addr;
      end else begin
        r_dm_addr <= r_dm_addr;
      end
      if (r_state == S_RD) begin
        r_buf <= dm_dout;
      end else begin
        r_buf <= r_buf;
      end
      if ((r_state == S_RD) && !r_wr) begin
        r_rdata <= load_ext(r_size, r_sext, dm_dout);
      end else begin
        r_rdata <= r_rdata;
      end
      r_done  <= (w_next == S_RESP);
      r_err   <= (r_state == S_IDLE) && (w_next == S_RESP);
      r_busy  <= (w_next != S_IDLE);
      r_dm_we <= (w_next == S_WR);
    end
  end

  assign rdata   = r_rdata;
  assign done    = r_done;
  assign err     = r_err;
  assign busy    = r_busy;
  assign dm_we   = r_dm_we;
  assign dm_addr = r_dm_addr;
  assign dm_din  = merge_store(r_size, r_buf, r_wdata);

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator-side load/store controller between the multicycle CPU datapath and the byte-addressed, little-endian data memory.
- The data memory has a combinational 32-bit read and a synchronous 32-bit write of bytes addr..addr+3; it has no byte enables.
- This block implements lb/lbu/lh/lhu/lw/sb/sh/sw through a request/done handshake. It performs sign/zero extension on loads and read-modify-write for sub-word stores.
- It rejects misaligned and out-of-range accesses without touching memory.

Parameters:
- ADDR_W, 14, byte-address width presented to data memory.
- DM_BYTES, 12288, data memory size in bytes; the last legal word base is DM_BYTES-4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  access request; sampled only in IDLE.
- wr  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal and reported as err.
- sext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  ADDR_W  byte address.
- wdata  input  32  store data (rt); low byte/halfword used for sb/sh.
- rdata  output  32  load result; valid when done=1.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: the access was rejected.
- busy  output  1  high in every state except IDLE.
- dm_addr  output  ADDR_W  address to data memory.
- dm_din  output  32  write data to data memory.
- dm_we  output  1  write enable to data memory.
- dm_dout  input  32  combinational read data from data memory.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - rdata, all request latches and the read buffer go to 0.
  - done, err, busy and dm_we go to 0.
  - dm_addr and dm_din go to 0.
  - Reset asserted mid-operation aborts the operation. No write is issued afterwards; if reset is asserted during WR, the pending write edge is lost.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - If req=1 at a rising edge, latch wr, size, sext, addr and wdata, then check the access.
  - Checks:
    - size=11 is illegal.
    - Halfword requires addr[0]=0.
    - Word requires addr[1:0]=00.
    - addr > DM_BYTES-4 is out of range, for every size.
  - Check fails: go to RESP with err=1.
  - Load, or byte/halfword store: go to RD.
  - Word store: go to WR.
- RD:
  - dm_addr = latched addr. Capture dm_dout into the read buffer at the edge.
  - Load: go to RESP.
  - Sub-word store: go to WR.
- WR:
  - dm_we=1 and dm_addr = latched addr for exactly one cycle. Memory commits at the edge leaving WR.
  - dm_din value:
    - sw: wdata.
    - sb: {buf[31:8], wdata[7:0]}.
    - sh: {buf[31:16], wdata[15:0]}.
  - Go to RESP.
- RESP:
  - done=1 for exactly one cycle, then go to IDLE.
  - For loads, rdata is loaded on entry to RESP and held until the next load completes:
    - lb: {24{sext&buf[7]}, buf[7:0]}.
    - lh: {16{sext&buf[15]}, buf[15:0]}.
    - lw: buf.
  - Stores and errors leave rdata unchanged.
- Latency from the req-sampling edge to done high:
  - Load or sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Error: 1 cycle.
- Handshake rules:
  - req asserted in any state other than IDLE is ignored and not queued.
  - req may be held high; a new request is accepted on the edge after RESP, i.e. back-to-back accesses are possible.
- Strobes: dm_we is never high outside WR and never high on an err access.
- dm_addr is held at the latched address in RD and WR. In IDLE and RESP it keeps its last value.
- busy = (state != IDLE).

Test Plan:
- Word round trip: sw addr=0x010 wdata=0xDEADBEEF, then lw 0x010.
  - Required: one dm_we pulse.
  - Required: rdata=0xDEADBEEF with done 2 cycles after req.
- Sign-extended byte load: memory word at 0x020 = 0x000000F0.
  - lb (sext=1) -> rdata=0xFFFFFFF0.
  - lbu -> rdata=0x000000F0.
- Byte store read-modify-write: memory word at 0x030 = 0x11223344; sb 0x030 wdata=0xAAAAAA55.
  - Required: dm_din=0x11223355 during WR; done at cycle 3.
  - Required: a following lw returns 0x11223355.
- Halfword store and signed halfword load: sh 0x040 wdata=0x0000BEEF over 0x12345678.
  - Required: memory becomes 0x1234BEEF.
  - Required: lh (sext=1) returns 0xFFFFBEEF.
- Errors:
  - lw 0x013 -> done and err in 1 cycle, no dm_we, rdata unchanged.
  - sw 0x2FFD (>12284) -> err=1.
  - size=11 -> err=1.
- Reset and busy handling:
  - rst_n=0 asserted while in WR of sb 0x050: no memory change, all outputs 0, state IDLE.
  - A second req raised while busy is ignored; exactly one done pulse is produced per accepted req.
